// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//
// Architectural register file with a rename tag per register. It sits
// downstream of the reorder buffer and tracks, for every architectural
// register, its retired value, whether an in-flight ROB entry will overwrite
// it (busy), and which ROB entry that is (tag).
//
// Handshake: each stream is a single-cycle valid strobe with no back-pressure.
// A launch or commit is taken on a rising clk_in edge when its *_ready strobe
// is high and rdy_in is high. rdy_in low freezes every piece of state. There
// is no ready return path, so the upstream ROB never stalls on this block.
//
// Ports:
//   clk_in, rst_in           clock, synchronous active-high reset
//   rdy_in                   global ready; low freezes all state
//   _clear                   flush: drop all busy flags and any same-cycle launch
//   _rf_launch_*             launch stream: register becomes owned by a ROB id
//   _rf_commit_*             commit stream: value retires into a register
//   _query_reg_1/2           source register indices from the decoder
//   _query_busy/rob_id/value combinational operand lookup for each port
//
// Build option:
//   RF_COMMIT_BYPASS_EN  when defined, a same-cycle commit is forwarded onto
//                        the query outputs; otherwise queries see registered
//                        state only.
// ---------------------------------------------------------------------------
module register_file #(
  parameter int XLEN     = 32,
  parameter int ROB_ID_W = 5,
  parameter int NREG     = 32
) (
  input  logic                clk_in,
  input  logic                rst_in,
  input  logic                rdy_in,
  input  logic                _clear,

  input  logic                _rf_launch_ready,
  input  logic [ROB_ID_W-1:0] _rf_launch_rob_id,
  input  logic [4:0]          _rf_launch_register_id,

  input  logic                _rf_commit_ready,
  input  logic [ROB_ID_W-1:0] _rf_commit_rob_id,
  input  logic [4:0]          _rf_commit_register_id,
  input  logic [XLEN-1:0]     _rf_commit_value,

  input  logic [4:0]          _query_reg_1,
  output logic                _query_busy_1,
  output logic [ROB_ID_W-1:0] _query_rob_id_1,
  output logic [XLEN-1:0]     _query_value_1,

  input  logic [4:0]          _query_reg_2,
  output logic                _query_busy_2,
  output logic [ROB_ID_W-1:0] _query_rob_id_2,
  output logic [XLEN-1:0]     _query_value_2
);

  localparam int LW = 1 + ROB_ID_W + XLEN;

  logic [XLEN-1:0]     value_q [NREG];
  logic                busy_q  [NREG];
  logic [ROB_ID_W-1:0] tag_q   [NREG];

  logic do_commit;
  logic do_launch;
  logic commit_hits_tag;

  // x0 is hardwired: writes to it are discarded here rather than masked later.
  assign do_commit = rdy_in && _rf_commit_ready && (_rf_commit_register_id != 5'd0);
  assign do_launch = rdy_in && _rf_launch_ready && !_clear &&
                     (_rf_launch_register_id != 5'd0);

  // A commit only releases the register if it is still the youngest producer.
  assign commit_hits_tag = busy_q[_rf_commit_register_id] &&
                           (tag_q[_rf_commit_register_id] == _rf_commit_rob_id);

  // Later assignments win: clear, then commit release, then launch, so a
  // same-register launch overrides the commit's busy/tag effect.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= '0;
      end
    end else if (rdy_in) begin
      if (_clear) begin
        for (int i = 0; i < NREG; i++) begin
          busy_q[i] <= 1'b0;
        end
      end
      if (do_commit) begin
        value_q[_rf_commit_register_id] <= _rf_commit_value;
        if (commit_hits_tag) begin
          busy_q[_rf_commit_register_id] <= 1'b0;
        end
      end
      if (do_launch) begin
        busy_q[_rf_launch_register_id] <= 1'b1;
        tag_q[_rf_launch_register_id]  <= _rf_launch_rob_id;
      end
    end
  end

  // Operand lookup, packed as {busy, rob_id, value}.
  function automatic logic [LW-1:0] lookup(input logic [4:0] r);
    logic                busy;
    logic [ROB_ID_W-1:0] rob_id;
    logic [XLEN-1:0]     value;
    busy   = busy_q[r];
    rob_id = tag_q[r];
    value  = value_q[r];
`ifdef RF_COMMIT_BYPASS_EN
    // Forward the retiring value; only release busy when the tag matches.
    if (do_commit && (_rf_commit_register_id == r)) begin
      value = _rf_commit_value;
      if (commit_hits_tag) begin
        busy = 1'b0;
      end
    end
`endif
    if (r == 5'd0) begin
      busy   = 1'b0;
      rob_id = '0;
      value  = '0;
    end
    return {busy, rob_id, value};
  endfunction

  always_comb begin
    {_query_busy_1, _query_rob_id_1, _query_value_1} = lookup(_query_reg_1);
  end

  always_comb begin
    {_query_busy_2, _query_rob_id_2, _query_value_2} = lookup(_query_reg_2);
  end

endmodule

// File: tb/tb_register_file.sv
// ---------------------------------------------------------------------------
// tb_register_file
//
// Directed scenarios followed by randomized launch/commit/clear traffic. A
// behavioural model (plain arrays of value/busy/tag) predicts every query
// result; expectations pass through an expected queue before comparison.
// ---------------------------------------------------------------------------
module tb_register_file;

  localparam int XLEN     = 32;
  localparam int ROB_ID_W = 5;
  localparam int NREG     = 32;

`ifdef RF_COMMIT_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic                clk_in = 1'b0;
  logic                rst_in = 1'b0;
  logic                rdy_in = 1'b0;
  logic                _clear = 1'b0;
  logic                _rf_launch_ready = 1'b0;
  logic [ROB_ID_W-1:0] _rf_launch_rob_id = '0;
  logic [4:0]          _rf_launch_register_id = '0;
  logic                _rf_commit_ready = 1'b0;
  logic [ROB_ID_W-1:0] _rf_commit_rob_id = '0;
  logic [4:0]          _rf_commit_register_id = '0;
  logic [XLEN-1:0]     _rf_commit_value = '0;
  logic [4:0]          _query_reg_1 = '0;
  logic                _query_busy_1;
  logic [ROB_ID_W-1:0] _query_rob_id_1;
  logic [XLEN-1:0]     _query_value_1;
  logic [4:0]          _query_reg_2 = '0;
  logic                _query_busy_2;
  logic [ROB_ID_W-1:0] _query_rob_id_2;
  logic [XLEN-1:0]     _query_value_2;

  register_file #(.XLEN(XLEN), .ROB_ID_W(ROB_ID_W), .NREG(NREG)) dut (
    .clk_in                 (clk_in),
    .rst_in                 (rst_in),
    .rdy_in                 (rdy_in),
    ._clear                 (_clear),
    ._rf_launch_ready       (_rf_launch_ready),
    ._rf_launch_rob_id      (_rf_launch_rob_id),
    ._rf_launch_register_id (_rf_launch_register_id),
    ._rf_commit_ready       (_rf_commit_ready),
    ._rf_commit_rob_id      (_rf_commit_rob_id),
    ._rf_commit_register_id (_rf_commit_register_id),
    ._rf_commit_value       (_rf_commit_value),
    ._query_reg_1           (_query_reg_1),
    ._query_busy_1          (_query_busy_1),
    ._query_rob_id_1        (_query_rob_id_1),
    ._query_value_1         (_query_value_1),
    ._query_reg_2           (_query_reg_2),
    ._query_busy_2          (_query_busy_2),
    ._query_rob_id_2        (_query_rob_id_2),
    ._query_value_2         (_query_value_2)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  // ---------------- reference model ----------------
  logic [XLEN-1:0]     m_val  [NREG];
  logic                m_busy [NREG];
  logic [ROB_ID_W-1:0] m_tag  [NREG];

  int n_vec = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) begin
      m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
  endtask

  // One clock edge worth of architectural effect, from the current inputs.
  task automatic model_step();
    int cr, lr;
    logic match;
    if (!rdy_in) return;
    cr = int'(_rf_commit_register_id);
    lr = int'(_rf_launch_register_id);
    match = m_busy[cr] && (m_tag[cr] == _rf_commit_rob_id);
    if (_rf_commit_ready && cr != 0) begin
      m_val[cr] = _rf_commit_value;
      if (match) m_busy[cr] = 1'b0;
    end
    if (_clear) begin
      for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
    end else if (_rf_launch_ready && lr != 0) begin
      m_busy[lr] = 1'b1;
      m_tag[lr]  = _rf_launch_rob_id;
    end
  endtask

  task automatic check(input string tag, input logic [XLEN-1:0] got,
                       input logic [XLEN-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%h expected=%h", tag, $time, got, exp);
    end
  endtask

  // Scoreboard: predict a port's result, queue it, then compare in order.
  task automatic check_port(input int p, input logic [4:0] r);
    logic [XLEN-1:0]     e_val;
    logic                e_busy;
    logic [ROB_ID_W-1:0] e_tag;
    logic                got_busy;
    logic [ROB_ID_W-1:0] got_tag;
    logic [XLEN-1:0]     got_val;
    e_val = m_val[r]; e_busy = m_busy[r]; e_tag = m_tag[r];
    if (BYPASS && rdy_in && _rf_commit_ready && _rf_commit_register_id == r) begin
      e_val = _rf_commit_value;
      if (e_busy && e_tag == _rf_commit_rob_id) e_busy = 1'b0;
    end
    if (r == 5'd0) begin
      e_val = '0; e_busy = 1'b0; e_tag = '0;
    end
    got_busy = (p == 1) ? _query_busy_1   : _query_busy_2;
    got_tag  = (p == 1) ? _query_rob_id_1 : _query_rob_id_2;
    got_val  = (p == 1) ? _query_value_1  : _query_value_2;
    exp_q.push_back(e_val);
    exp_q.push_back(XLEN'(e_busy));
    exp_q.push_back(XLEN'(e_tag));
    check($sformatf("value%0d x%0d", p, r), got_val, exp_q.pop_front());
    check($sformatf("busy%0d x%0d", p, r), XLEN'(got_busy), exp_q.pop_front());
    // rob_id carries meaning only while busy (and is fixed at 0 for x0).
    if (e_busy || r == 5'd0) check($sformatf("rob_id%0d x%0d", p, r), XLEN'(got_tag), exp_q.pop_front());
    else void'(exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_in = 1'b1;
    rdy_in = 1'b0;  // reset must still win with the pipeline frozen
    _rf_launch_ready = 1'b1; _rf_launch_register_id = 5'd9; _rf_launch_rob_id = 5'd3;
    _rf_commit_ready = 1'b1; _rf_commit_register_id = 5'd9; _rf_commit_value = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk_in);
    model_reset();
    #1;
    rst_in = 1'b0;
  endtask

  task automatic drive(input logic rdy, input logic clr,
                       input logic lv, input logic [4:0] lreg, input logic [4:0] lid,
                       input logic cv, input logic [4:0] creg, input logic [4:0] cid,
                       input logic [XLEN-1:0] cval,
                       input logic [4:0] q1, input logic [4:0] q2);
    rdy_in = rdy; _clear = clr;
    _rf_launch_ready = lv; _rf_launch_register_id = lreg; _rf_launch_rob_id = lid;
    _rf_commit_ready = cv; _rf_commit_register_id = creg; _rf_commit_rob_id = cid;
    _rf_commit_value = cval;
    _query_reg_1 = q1; _query_reg_2 = q2;
    @(negedge clk_in);
    check_port(1, q1);
    check_port(2, q2);
    @(posedge clk_in);
    model_step();
    #1;
  endtask

  task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 5'd0, '0, q1, q2);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] lreg, creg, cid;
    do_reset();
    idle(5'd5, 5'd0);

    // Launch then matching commit.
    drive(1, 0, 1, 5'd3, 5'd7, 0, 5'd0, 5'd0, '0, 5'd3, 5'd3);
    drive(1, 0, 0, 5'd0, 5'd0, 1, 5'd3, 5'd7, 32'hDEADBEEF, 5'd3, 5'd0);
    idle(5'd3, 5'd3);

    // Stale commit leaves the younger producer in charge.
    drive(1, 0, 1, 5'd4, 5'd2, 0, 5'd0, 5'd0, '0, 5'd4, 5'd0);
    drive(1, 0, 1, 5'd4, 5'd9, 0, 5'd0, 5'd0, '0, 5'd4, 5'd0);
    drive(1, 0, 0, 5'd0, 5'd0, 1, 5'd4, 5'd2, 32'h11, 5'd4, 5'd4);
    drive(1, 0, 0, 5'd0, 5'd0, 1, 5'd4, 5'd9, 32'h22, 5'd4, 5'd0);
    idle(5'd4, 5'd4);

    // Same-cycle commit and launch to one register: launch owns busy/tag.
    drive(1, 0, 1, 5'd6, 5'd1, 0, 5'd0, 5'd0, '0, 5'd6, 5'd0);
    drive(1, 0, 1, 5'd6, 5'd4, 1, 5'd6, 5'd1, 32'h55, 5'd6, 5'd6);
    idle(5'd6, 5'd6);

    // Clear with a commit and a launch in the same cycle.
    drive(1, 0, 1, 5'd1, 5'd3, 0, 5'd0, 5'd0, '0, 5'd1, 5'd2);
    drive(1, 0, 1, 5'd2, 5'd5, 0, 5'd0, 5'd0, '0, 5'd1, 5'd2);
    drive(1, 1, 1, 5'd7, 5'd6, 1, 5'd1, 5'd3, 32'hAB, 5'd1, 5'd2);
    idle(5'd1, 5'd2);
    idle(5'd7, 5'd1);

    // Frozen pipeline, then an attempt to claim x0.
    drive(0, 0, 1, 5'd8, 5'd10, 1, 5'd8, 5'd10, 32'h1234, 5'd8, 5'd8);
    idle(5'd8, 5'd0);
    drive(1, 0, 1, 5'd0, 5'd11, 1, 5'd0, 5'd0, 32'h77, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Tag-matching commit observed in its own cycle.
    drive(1, 0, 1, 5'd3, 5'd12, 0, 5'd0, 5'd0, '0, 5'd3, 5'd0);
    drive(1, 0, 0, 5'd0, 5'd0, 1, 5'd3, 5'd12, 32'h99, 5'd3, 5'd3);
    idle(5'd3, 5'd0);

    // Randomized traffic over a small register window to force collisions.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) begin
        do_reset();
        idle(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      end
      lreg = 5'($urandom_range(0, 7));
      creg = 5'($urandom_range(0, 7));
      cid  = ($urandom_range(0, 1) == 0) ? m_tag[creg] : 5'($urandom_range(0, 31));
      drive(1'($urandom_range(0, 9) != 0),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 9) < 6), lreg, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 9) < 6), creg, cid, $urandom,
            ($urandom_range(0, 2) == 0) ? creg : 5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural register file with per-register rename tags; sits directly downstream of the reorder buffer.
- Consumes the ROB launch stream (rd becomes dependent on a ROB entry) and the commit stream (value retires into the architectural register).
- Serves two combinational source-operand queries for the decoder: value, busy flag and producing ROB id.
- A busy register's id is then used by the decoder to probe the ROB.

Parameters:
XLEN, 32, data width of each register
ROB_ID_W, 5, width of a ROB entry id
NREG, 32, number of architectural registers (index width fixed at 5)

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; low freezes all state
_clear  input  1  pipeline flush (mispredict)
_rf_launch_ready  input  1  launch valid
_rf_launch_rob_id  input  ROB_ID_W  ROB entry producing rd
_rf_launch_register_id  input  5  destination register
_rf_commit_ready  input  1  commit valid
_rf_commit_rob_id  input  ROB_ID_W  committing ROB entry
_rf_commit_register_id  input  5  destination register
_rf_commit_value  input  XLEN  retired value
_query_reg_1  input  5  source register 1 index
_query_busy_1  output  1  reg 1 awaits an in-flight producer
_query_rob_id_1  output  ROB_ID_W  producing ROB id (valid when busy)
_query_value_1  output  XLEN  architectural value of reg 1
_query_reg_2  input  5  source register 2 index
_query_busy_2  output  1  as above, port 2
_query_rob_id_2  output  ROB_ID_W  as above, port 2
_query_value_2  output  XLEN  as above, port 2

Behaviour:
- State per register: value[XLEN], busy, tag[ROB_ID_W].
- Reset: all values 0, all busy 0, all tags 0. Reset overrides rdy_in and every other input.
- Query outputs are combinational from registered state, except as modified by the optional feature.
- Reset output values: busy 0, rob_id 0, value 0 for every index.
- rdy_in low: no state change; queries remain valid.
- x0 handling:
  - Reads always return value 0, busy 0, rob_id 0.
  - Launch or commit to register 0 is ignored.
- Commit (rdy_in high, _rf_commit_ready high, reg r != 0):
  - value[r] <= commit_value.
  - If busy[r] and tag[r] == commit_rob_id, then busy[r] <= 0.
  - A tag mismatch leaves busy and tag untouched, because a younger producer exists.
- Launch (rdy_in high, _rf_launch_ready high, _clear low, reg r != 0): busy[r] <= 1, tag[r] <= launch_rob_id.
- Launch and commit in the same cycle to the same register:
  - The value is written from the commit.
  - busy/tag take the launch result; the launch wins.
- Launch and commit to different registers: both apply independently.
- _clear (rdy_in high):
  - All busy cleared; tags are don't-care.
  - Values retained.
  - Any commit in the same cycle still writes its value.
  - Any launch in the same cycle is dropped.
- Latency: all updates become visible on query outputs the cycle after the edge.

Optional Feature:
- Macro: RF_COMMIT_BYPASS_EN.
- Defined: a query of reg r != 0 while a same-cycle commit targets r with tag match and busy[r] set returns busy 0 and value = _rf_commit_value combinationally.
- Defined: a commit to r without a tag match still forwards its value on the value output, while busy/rob_id stay as registered.
- Undefined: query outputs reflect registered state only, so a commit becomes visible one cycle later.

Test Plan:
- Reset, then query x5/x0 -> busy 0, value 0, rob_id 0 on both ports.
- Launch x3 rob 7; next cycle commit x3 rob 7 value 0xDEADBEEF -> after launch busy 1, rob_id 7; after commit busy 0, value 0xDEADBEEF.
- Launch x4 rob 2, launch x4 rob 9, commit x4 rob 2 value 0x11 -> value 0x11, busy 1, rob_id 9; then commit rob 9 value 0x22 -> busy 0, value 0x22.
- Same cycle: commit x6 rob 1 value 0x55 with x6 busy tag 1, plus launch x6 rob 4 -> value 0x55, busy 1, rob_id 4.
- Launch x1/x2 (rob 3/5), then _clear with commit x1 rob 3 value 0xAB and launch x7 rob 6 -> x1 value 0xAB busy 0, x2 busy 0, x7 busy 0.
- rdy_in low with launch/commit x8 asserted -> no change. Launch x0 -> x0 stays busy 0. With RF_COMMIT_BYPASS_EN: commit x3 tag-match value 0x99 -> same-cycle query shows busy 0, value 0x99.
